// File: rtl/sy_pkg.sv
// Shared TileLink-UL types and opcodes, plus GPIO register offsets and the
// request/response FSM state type.
package sy_pkg;

   localparam int unsigned TL_AW   = 32;
   localparam int unsigned TL_DW   = 64;
   localparam int unsigned TL_MW   = TL_DW / 8;
   localparam int unsigned TL_SRCW = 4;
   localparam int unsigned TL_SZW  = 3;

   localparam logic [2:0] TL_PUT_FULL    = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] TL_GET         = 3'd4;
   localparam logic [2:0] TL_ACK         = 3'd0;
   localparam logic [2:0] TL_ACK_DATA    = 3'd1;

   localparam logic [5:0] GPIO_IN_OFS      = 6'h00;
   localparam logic [5:0] GPIO_OUT_OFS     = 6'h08;
   localparam logic [5:0] GPIO_OE_OFS      = 6'h10;
   localparam logic [5:0] GPIO_RISE_EN_OFS = 6'h18;
   localparam logic [5:0] GPIO_FALL_EN_OFS = 6'h20;
   localparam logic [5:0] GPIO_STATUS_OFS  = 6'h28;
   localparam logic [5:0] GPIO_OUT_SET_OFS = 6'h30;
   localparam logic [5:0] GPIO_OUT_CLR_OFS = 6'h38;

   typedef struct packed {
      logic [2:0]         opcode;
      logic [2:0]         param;
      logic [TL_SZW-1:0]  size;
      logic [TL_SRCW-1:0] source;
      logic [TL_AW-1:0]   address;
      logic [TL_MW-1:0]   mask;
      logic [TL_DW-1:0]   data;
      logic               corrupt;
   } tl_a_t;

   typedef struct packed {
      logic [2:0]         opcode;
      logic [1:0]         param;
      logic [TL_SZW-1:0]  size;
      logic [TL_SRCW-1:0] source;
      logic               sink;
      logic               denied;
      logic [TL_DW-1:0]   data;
      logic               corrupt;
   } tl_d_t;

   typedef enum logic {IDLE, RESP} gpio_tl_state_e;

   // Expand a per-byte write mask into a per-bit mask.
   function automatic logic [TL_DW-1:0] tl_mask_bits(input logic [TL_MW-1:0] m);
      logic [TL_DW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < TL_MW; i++) begin
         r[i*8 +: 8] = {8{m[i]}};
      end
      return r;
   endfunction

endpackage

// File: rtl/sy_tl_bus.sv
// TileLink-UL A/B/D channel bundle; the Master modport is the view taken by
// a peripheral sitting on the crossbar.
interface TL_BUS;
   import sy_pkg::*;

   logic  a_valid;
   logic  a_ready;
   tl_a_t a_bits;
   logic  b_valid;
   logic  d_valid;
   logic  d_ready;
   tl_d_t d_bits;

   modport Master (
      input  a_valid, a_bits, d_ready,
      output a_ready, d_valid, d_bits, b_valid
   );
endinterface

// File: rtl/sy_gpio_in_cond.sv
// GPIO input conditioning: synchroniser, optional debounce and edge detect.
// Debounce is compiled in with SY_GPIO_DEBOUNCE_EN.
module sy_gpio_in_cond #(
   parameter int unsigned W               = 32,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] gpio_i,
   output logic [W-1:0] in_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);

   logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
   logic [W-1:0] sync_val;
   logic [W-1:0] deb;
   logic [W-1:0] prev_q, prev_d;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], gpio_i};
      sync_val = sync_q[SYNC_STAGES-1];
      prev_d   = deb;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

`ifdef SY_GPIO_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [W-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]            deb_q, deb_d;

   // A pin must differ from its debounced value for DEBOUNCE_CYCLES
   // consecutive cycles before the new level is accepted.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int unsigned i = 0; i < W; i++) begin
         if (sync_val[i] != deb_q[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (cnt_d[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
               deb_d[i] = sync_val[i];
               cnt_d[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
         deb_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   assign deb = deb_q;
`else
   localparam int unsigned unused_deb_cycles = DEBOUNCE_CYCLES;
   assign deb = sync_val;
`endif

   assign in_o   = deb;
   assign rise_o = deb & ~prev_q;
   assign fall_o = ~deb & prev_q;

endmodule

// File: rtl/sy_gpio_ctrl.sv
// TileLink-UL GPIO controller: direction, W1S/W1C output update and latched
// edge interrupts. Optional input debounce via SY_GPIO_DEBOUNCE_EN.
module sy_gpio_ctrl
   import sy_pkg::*;
#(
   parameter int unsigned GPIO_W          = 32,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   TL_BUS.Master             master,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [GPIO_W-1:0] gpio_oe_o,
   output logic              irq_o
);

   gpio_tl_state_e state_q, state_d;
   tl_d_t          rsp_q, rsp_d;

   logic [GPIO_W-1:0] out_q, out_d;
   logic [GPIO_W-1:0] oe_q, oe_d;
   logic [GPIO_W-1:0] rise_en_q, rise_en_d;
   logic [GPIO_W-1:0] fall_en_q, fall_en_d;
   logic [GPIO_W-1:0] status_q, status_d;

   logic [GPIO_W-1:0] in_val, rise, fall;
   tl_a_t             a_req;
   logic [TL_DW-1:0]  full_mask, rdata;
   logic [GPIO_W-1:0] wmask, wbits, w1c;
   logic [2:0]        reg_idx;
   logic              accept, is_get, is_put, wr;

   sy_gpio_in_cond #(
      .W               (GPIO_W),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_in_cond (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .gpio_i (gpio_i),
      .in_o   (in_val),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign a_req = master.a_bits;

   always_comb begin
      accept    = (state_q == IDLE) && master.a_valid;
      is_get    = (a_req.opcode == TL_GET);
      is_put    = (a_req.opcode == TL_PUT_FULL) || (a_req.opcode == TL_PUT_PARTIAL);
      wr        = accept && is_put;
      reg_idx   = a_req.address[5:3];
      full_mask = tl_mask_bits(a_req.mask);
      wmask     = full_mask[GPIO_W-1:0];
      wbits     = a_req.data[GPIO_W-1:0] & wmask;
      w1c       = (wr && reg_idx == GPIO_STATUS_OFS[5:3]) ? wbits : '0;
   end

   // Register updates; a new edge event beats a same-cycle W1C clear.
   always_comb begin
      out_d     = out_q;
      oe_d      = oe_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      status_d  = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
      if (wr) begin
         case (reg_idx)
            GPIO_OUT_OFS[5:3]:     out_d     = (out_q & ~wmask) | wbits;
            GPIO_OE_OFS[5:3]:      oe_d      = (oe_q & ~wmask) | wbits;
            GPIO_RISE_EN_OFS[5:3]: rise_en_d = (rise_en_q & ~wmask) | wbits;
            GPIO_FALL_EN_OFS[5:3]: fall_en_d = (fall_en_q & ~wmask) | wbits;
            GPIO_OUT_SET_OFS[5:3]: out_d     = out_q | wbits;
            GPIO_OUT_CLR_OFS[5:3]: out_d     = out_q & ~wbits;
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_idx)
         GPIO_IN_OFS[5:3]:      rdata[GPIO_W-1:0] = in_val;
         GPIO_OUT_OFS[5:3]:     rdata[GPIO_W-1:0] = out_q;
         GPIO_OE_OFS[5:3]:      rdata[GPIO_W-1:0] = oe_q;
         GPIO_RISE_EN_OFS[5:3]: rdata[GPIO_W-1:0] = rise_en_q;
         GPIO_FALL_EN_OFS[5:3]: rdata[GPIO_W-1:0] = fall_en_q;
         GPIO_STATUS_OFS[5:3]:  rdata[GPIO_W-1:0] = status_q;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rsp_d        = '0;
               rsp_d.opcode = is_get ? TL_ACK_DATA : TL_ACK;
               rsp_d.size   = a_req.size;
               rsp_d.source = a_req.source;
               rsp_d.denied = !(is_get || is_put);
               rsp_d.data   = is_get ? rdata : '0;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (master.d_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         rsp_q     <= '0;
         out_q     <= '0;
         oe_q      <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         rsp_q     <= rsp_d;
         out_q     <= out_d;
         oe_q      <= oe_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
      end
   end

   assign master.a_ready = (state_q == IDLE);
   assign master.d_valid = (state_q == RESP);
   assign master.d_bits  = rsp_q;
   assign master.b_valid = 1'b0;

   assign gpio_o    = out_q;
   assign gpio_oe_o = oe_q;
   assign irq_o     = |(status_q & (rise_en_q | fall_en_q));

   logic unused_tl;
   assign unused_tl = ^{a_req.param, a_req.corrupt, a_req.address[TL_AW-1:6],
                        a_req.address[2:0], a_req.data, full_mask};

endmodule

// File: tb/tb_sy_gpio_ctrl.sv
// Directed bench for sy_gpio_ctrl: register access, W1S/W1C, edge interrupts,
// response stall and reset during a pending response.
module tb_sy_gpio_ctrl;
   import sy_pkg::*;

`ifdef SY_GPIO_DEBOUNCE_EN
   localparam int DEB = 8;
`else
   localparam int DEB = 0;
`endif

   logic        clk;
   logic        rst_i;
   logic [31:0] gpio_i;
   logic [31:0] gpio_o;
   logic [31:0] gpio_oe_o;
   logic        irq_o;
   int          passed;
   int          total;

   TL_BUS bus ();

   sy_gpio_ctrl #(
      .GPIO_W          (32),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .master    (bus),
      .gpio_i    (gpio_i),
      .gpio_o    (gpio_o),
      .gpio_oe_o (gpio_oe_o),
      .irq_o     (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic xfer(input logic [2:0] op, input logic [5:0] ofs, input logic [7:0] m,
                       input logic [63:0] data, output logic [63:0] rd,
                       output logic [2:0] dop, output logic den);
      tl_a_t req;
      @(negedge clk);
      check("a_ready_idle", 64'(bus.a_ready), 64'd1);
      req         = '0;
      req.opcode  = op;
      req.size    = 3'd3;
      req.source  = 4'h5;
      req.address = {26'h0, ofs};
      req.mask    = m;
      req.data    = data;
      bus.a_bits  = req;
      bus.a_valid = 1'b1;
      @(posedge clk); #1;
      bus.a_valid = 1'b0;
      check("d_valid_latency", 64'(bus.d_valid), 64'd1);
      check("d_source", 64'(bus.d_bits.source), 64'h5);
      rd  = bus.d_bits.data;
      dop = bus.d_bits.opcode;
      den = bus.d_bits.denied;
      @(posedge clk); #1;
      check("d_valid_drop", 64'(bus.d_valid), 64'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] ofs, input logic [63:0] exp);
      logic [63:0] rd;
      logic [2:0]  dop;
      logic        den;
      xfer(TL_GET, ofs, 8'hFF, 64'h0, rd, dop, den);
      check({tag, "_data"}, rd, exp);
      check({tag, "_opc"}, 64'({den, dop}), 64'({1'b0, TL_ACK_DATA}));
   endtask

   task automatic wr(input logic [5:0] ofs, input logic [63:0] data, input logic [7:0] m);
      logic [63:0] rd;
      logic [2:0]  dop;
      logic        den;
      xfer((m == 8'hFF) ? TL_PUT_FULL : TL_PUT_PARTIAL, ofs, m, data, rd, dop, den);
      check("put_ack", 64'({den, dop}), 64'({1'b0, TL_ACK}));
   endtask

   task automatic edge_lat(input string tag);
      repeat (2 + DEB) @(posedge clk);
      #1 check({tag, "_early"}, 64'(irq_o), 64'd0);
      @(posedge clk);
      #1 check({tag, "_set"}, 64'(irq_o), 64'd1);
   endtask

   initial begin
      logic [63:0] rd;
      logic [2:0]  dop;
      logic        den;
      passed      = 0;
      total       = 0;
      rst_i       = 1'b0;
      gpio_i      = '0;
      bus.a_valid = 1'b0;
      bus.a_bits  = '0;
      bus.d_ready = 1'b1;
      #1;
      check("rst_gpio_o", 64'(gpio_o), 64'h0);
      check("rst_oe", 64'(gpio_oe_o), 64'h0);
      check("rst_irq", 64'(irq_o), 64'h0);
      check("rst_dvalid", 64'(bus.d_valid), 64'h0);
      check("rst_aready", 64'(bus.a_ready), 64'h1);
      check("rst_bvalid", 64'(bus.b_valid), 64'h0);
      repeat (3) @(negedge clk);
      rst_i = 1'b1;

      for (int i = 0; i < 8; i++) rd_chk("rst_reg", 6'(i * 8), 64'h0);

      wr(GPIO_OUT_OFS, 64'hA5A5_A5A5, 8'hFF);
      wr(GPIO_OE_OFS, 64'hFFFF_FFFF, 8'hFF);
      wr(GPIO_OUT_SET_OFS, 64'h0000_000A, 8'hFF);
      check("set_gpio_o", 64'(gpio_o), 64'hA5A5_A5AF);
      wr(GPIO_OUT_CLR_OFS, 64'h0000_0005, 8'hFF);
      check("clr_gpio_o", 64'(gpio_o), 64'hA5A5_A5AA);
      check("oe_out", 64'(gpio_oe_o), 64'hFFFF_FFFF);
      rd_chk("out_rd", GPIO_OUT_OFS, 64'hA5A5_A5AA);
      rd_chk("oe_rd", GPIO_OE_OFS, 64'hFFFF_FFFF);
      rd_chk("outset_rd", GPIO_OUT_SET_OFS, 64'h0);
      rd_chk("outclr_rd", GPIO_OUT_CLR_OFS, 64'h0);

      wr(GPIO_OUT_OFS, 64'h0, 8'hFF);
      wr(GPIO_OUT_OFS, 64'h0000_FF00, 8'h02);
      check("partial_b1", 64'(gpio_o), 64'h0000_FF00);
      wr(GPIO_OUT_OFS, 64'h1234_5678, 8'h01);
      check("partial_b0", 64'(gpio_o), 64'h0000_FF78);
      wr(GPIO_OUT_OFS, 64'hFFFF_FFFF, 8'h00);
      check("partial_none", 64'(gpio_o), 64'h0000_FF78);
      xfer(3'd2, GPIO_OUT_OFS, 8'hFF, 64'hFFFF_FFFF, rd, dop, den);
      check("bad_op_resp", 64'({den, dop}), 64'({1'b1, TL_ACK}));
      check("bad_op_noeff", 64'(gpio_o), 64'h0000_FF78);

      wr(GPIO_RISE_EN_OFS, 64'h1, 8'hFF);
      wr(GPIO_FALL_EN_OFS, 64'h2, 8'hFF);
      gpio_i[0] = 1'b1;
      edge_lat("rise0");
      rd_chk("st_rise0", GPIO_STATUS_OFS, 64'h1);
      wr(GPIO_STATUS_OFS, 64'h1, 8'hFF);
      check("w1c_irq", 64'(irq_o), 64'h0);
      gpio_i[1] = 1'b1;
      repeat (6 + DEB) @(posedge clk);
      #1 rd_chk("st_rise_unen", GPIO_STATUS_OFS, 64'h0);
      gpio_i[1] = 1'b0;
      edge_lat("fall1");
      gpio_i[0] = 1'b0;
      repeat (6 + DEB) @(posedge clk);
      #1 rd_chk("st_fall_unen", GPIO_STATUS_OFS, 64'h2);
      gpio_i[0] = 1'b1;
      repeat (6 + DEB) @(posedge clk);
      #1 rd_chk("st_both", GPIO_STATUS_OFS, 64'h3);
      check("irq_both", 64'(irq_o), 64'h1);
      rd_chk("in_rd", GPIO_IN_OFS, 64'h1);
      wr(GPIO_STATUS_OFS, 64'h1, 8'hFF);
      rd_chk("st_w1c", GPIO_STATUS_OFS, 64'h2);
      wr(GPIO_FALL_EN_OFS, 64'h0, 8'hFF);
      check("irq_masked", 64'(irq_o), 64'h0);
      wr(GPIO_FALL_EN_OFS, 64'h2, 8'hFF);
      check("irq_unmasked", 64'(irq_o), 64'h1);

      // Rising edge on pin 0 lands on the same edge that accepts the W1C.
      gpio_i[0] = 1'b0;
      repeat (6 + DEB) @(posedge clk);
      #1 gpio_i[0] = 1'b1;
      repeat (2 + DEB) @(posedge clk);
      wr(GPIO_STATUS_OFS, 64'h1, 8'hFF);
      rd_chk("st_collide", GPIO_STATUS_OFS, 64'h3);
      wr(GPIO_STATUS_OFS, 64'h3, 8'hFF);
      rd_chk("st_cleared", GPIO_STATUS_OFS, 64'h0);
      check("irq_cleared", 64'(irq_o), 64'h0);

`ifdef SY_GPIO_DEBOUNCE_EN
      wr(GPIO_RISE_EN_OFS, 64'h8, 8'hFF);
      gpio_i[3] = 1'b1;
      repeat (5) @(posedge clk);
      #1 gpio_i[3] = 1'b0;
      repeat (20) @(posedge clk);
      #1 rd_chk("st_glitch", GPIO_STATUS_OFS, 64'h0);
      gpio_i[3] = 1'b1;
      edge_lat("deb_rise3");
      repeat (10) @(posedge clk);
      #1 gpio_i[3] = 1'b0;
      wr(GPIO_STATUS_OFS, 64'h8, 8'hFF);
`endif

      bus.d_ready = 1'b0;
      @(negedge clk);
      bus.a_bits         = '0;
      bus.a_bits.opcode  = TL_GET;
      bus.a_bits.address = 32'(GPIO_OUT_OFS);
      bus.a_bits.mask    = 8'hFF;
      bus.a_valid        = 1'b1;
      @(posedge clk); #1;
      bus.a_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("stall_hs", 64'({bus.d_valid, bus.a_ready}), 64'h2);
         check("stall_data", bus.d_bits.data, 64'h0000_FF78);
         @(posedge clk); #1;
      end
      bus.d_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release", 64'(bus.d_valid), 64'h0);

      bus.d_ready = 1'b0;
      @(negedge clk);
      bus.a_valid = 1'b1;
      @(posedge clk); #1;
      bus.a_valid = 1'b0;
      check("pend_dvalid", 64'(bus.d_valid), 64'h1);
      #2 rst_i = 1'b0;
      #1;
      check("async_dvalid", 64'(bus.d_valid), 64'h0);
      check("async_aready", 64'(bus.a_ready), 64'h1);
      check("async_out", 64'({gpio_o, gpio_oe_o}), 64'h0);
      @(negedge clk);
      rst_i       = 1'b1;
      bus.d_ready = 1'b1;
      repeat (12 + DEB) @(posedge clk);
      #1 rd_chk("loopback_in", GPIO_IN_OFS, 64'h1);
      rd_chk("post_rst_out", GPIO_OUT_OFS, 64'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
